sram2axi_wr_engine: RTL
=======================

// Module: sram2axi_wr_engine
// PURPOSE
//  Write half of the sram2axi bridge. Converts data-SRAM-style write requests (req/addr_ok/data_ok) into
//  single-beat AXI3 writes on AW, W and B, with parametrised width and up to MAX_OUTSTANDING writes in flight.
//  AW and W handshake independently. data_ok is returned on the B response. Sits between the CPU data port and the AXI crossbar.
// PARAMETERS
//  AXI_ID           4'd1  awid/wid value driven on every write
//  ADDR_W           32    address width
//  DATA_W           32    data width, 32 or 64; STRB_W = DATA_W/8 (localparam)
//  MAX_OUTSTANDING  2     max writes accepted but not yet answered on B (1..8)
// PORTS
//  clk                clk   in   1        single clock, rising edge
//  reset              in   1        synchronous, active-low (0 = reset)
//  data_sram_req      in   1        request valid
//  data_sram_wr       in   1        1 = write; reads are ignored here
//  data_sram_size     in   3        log2 bytes, copied to awsize
//  data_sram_wstrb    in   STRB_W   byte enables
//  data_sram_addr     in   ADDR_W   byte address
//  data_sram_wdata    in   DATA_W   write data
//  data_sram_addr_ok  out  1        request accepted this cycle
//  data_sram_data_ok  out  1        one write completed (B handshake)
//  awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/ADDR_W/8/3/2/2/4/3/1
//  awready            in   1
//  wid/wdata/wstrb/wlast/wvalid   out  4/DATA_W/STRB_W/1/1
//  wready             in   1
//  bid/bresp/bvalid   in   4/2/1    bid and bresp are ignored
//  bready             out  1
//  wr_busy            out  1        outstanding count != 0 or state != IDLE
// BEHAVIOUR
//  - Constants: awlen=0, awburst=2'b01, awlock=0, awcache=0, awprot=0, wlast=1, awid=wid=AXI_ID.
//  - FSM IDLE/SEND. addr_ok = req & wr & IDLE & (cnt < MAX_OUTSTANDING); combinational.
//  - On accept: addr/size/wstrb/wdata go to registers. Next cycle awvalid=wvalid=1, state=SEND.
//  - SEND: awvalid falls after awvalid&awready; wvalid falls after wvalid&wready. Either order or the same cycle.
//    Move to IDLE in the cycle the last of the two handshakes completes. Earliest next accept is the following cycle.
//  - awaddr/awsize/wdata/wstrb stay stable while the corresponding valid is high; valid never drops without a handshake.
//  - cnt: +1 on accept, -1 on bvalid&bready, unchanged if both happen. It never exceeds MAX_OUTSTANDING.
//    At cnt==MAX, accept stays blocked even when a B arrives that cycle (no bypass).
//  - bready = (cnt != 0). data_ok = bvalid & bready: a 1-cycle pulse per B, returned in order.
//  - Reset values: awvalid=wvalid=bready=0, addr_ok=data_ok=0, cnt=0, state=IDLE.
//    awaddr/wdata/wstrb/awsize = 0; wr_busy = 0.
//  - Reset in mid-transaction drops all state (system-wide reset only).
// CONFIGURATION
//  `SRAM2AXI_WR_HAZARD_EN defined:
//    - Adds port hz_addr (in, ADDR_W) and port hz_hit (out, 1).
//    - Outstanding write addresses are kept in an in-order FIFO: push on accept, pop on B.
//    - hz_hit = any valid entry with addr[ADDR_W-1:$clog2(STRB_W)] equal to hz_addr's, OR an active SEND address match.
//      Combinational; the read side uses it to stall loads.
//  Not defined: the ports and the FIFO are absent; only the counter is built.
// STRUCTURE
//  - Package sram2axi_pkg holds the AXI constants (BURST_INCR, LEN_SINGLE, RESP_OKAY) and the IDLE/SEND state enum.
//  - One sub-module, wr_pending_fifo (depth MAX_OUTSTANDING, width ADDR_W, full/empty, match port).
//    It is instantiated only under the macro.
// TESTING
//  1 Write to 0x1000, data 0xDEADBEEF, strb 0xF, size 2, awready=wready=1.
//    -> addr_ok in cycle 0; cycle 1 shows awvalid=wvalid=1 with those values.
//    -> bvalid 3 cycles later gives one data_ok pulse; wr_busy returns to 0.
//  2 wready=1, awready held 0 for 3 cycles -> wvalid lasts 1 cycle; awvalid is held with awaddr stable.
//    -> IDLE the cycle after the AW handshake; no new addr_ok before then.
//  3 MAX_OUTSTANDING=2, three back-to-back writes, no B -> the third gets addr_ok=0.
//    -> Give B while cnt==2 with the request held -> still 0 that cycle, accepted the next.
//  4 reset=0 during SEND with awvalid=1 -> the next cycle shows awvalid=wvalid=bready=0, wr_busy=0.
//    -> A new write after reset=1 behaves as in test 1.
//  5 req=1, wr=0 -> addr_ok=0, no AW/W activity, cnt unchanged.
//  6 (macro) Write to 0x2000 outstanding, hz_addr=0x2002 -> hz_hit=1; hz_addr=0x2004 -> 0.
//    -> After the B for 0x2000, hz_hit=0 for 0x2002.

Source files
------------

// File: rtl/sram2axi_wr_engine_pkg.sv
// sram2axi_pkg: AXI constants and write-engine state type shared across the bridge
package sram2axi_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [7:0] LEN_SINGLE = 8'd0;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    typedef enum logic {IDLE, SEND} wr_state_e;
endpackage

// File: rtl/sram2axi_wr_engine_if.sv
// sram2axi_wr_engine_if: AXI3 write channels (AW, W, B) between the engine and the crossbar
interface sram2axi_wr_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;
    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [3:0]        wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram2axi_wr_engine_fifo.sv
// wr_pending_fifo: in-order outstanding write addresses with word-granular match (built only with SRAM2AXI_WR_HAZARD_EN)
`ifdef SRAM2AXI_WR_HAZARD_EN
module wr_pending_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    parameter int LSB   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic [WIDTH-1:0] match_addr,
    output logic             full,
    output logic             empty,
    output logic             match
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    wp, rp;
    logic             unused_lsb;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign full       = vld[wp];
    assign empty      = !vld[rp];
    assign unused_lsb = ^match_addr[LSB-1:0];
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld <= '0;
            wp  <= '0;
            rp  <= '0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                vld[wp] <= 1'b1;
                wp      <= inc(wp);
            end
            if (pop) begin
                vld[rp] <= 1'b0;
                rp      <= inc(rp);
            end
        end
    end
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            match |= vld[i] && (mem[i][WIDTH-1:LSB] == match_addr[WIDTH-1:LSB]);
    end
endmodule
`endif

// File: rtl/sram2axi_wr_engine.sv
// sram2axi_wr_engine: SRAM write requests to single-beat AXI3 writes; SRAM2AXI_WR_HAZARD_EN adds hz_addr/hz_hit store hazard check
module sram2axi_wr_engine
    import sram2axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID          = 4'd1,
    parameter int         ADDR_W          = 32,
    parameter int         DATA_W          = 32,
    parameter int         MAX_OUTSTANDING = 2,
    localparam int        STRB_W          = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_sram_req,
    input  logic                     data_sram_wr,
    input  logic [2:0]               data_sram_size,
    input  logic [STRB_W-1:0]        data_sram_wstrb,
    input  logic [ADDR_W-1:0]        data_sram_addr,
    input  logic [DATA_W-1:0]        data_sram_wdata,
    output logic                     data_sram_addr_ok,
    output logic                     data_sram_data_ok,
    sram2axi_wr_engine_if.master     axi,
`ifdef SRAM2AXI_WR_HAZARD_EN
    input  logic [ADDR_W-1:0]        hz_addr,
    output logic                     hz_hit,
`endif
    output logic                     wr_busy
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    wr_state_e         state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              awvalid_q, wvalid_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [2:0]        awsize_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              accept, room, aw_hs, w_hs, b_hs, send_done, unused;
`ifdef SRAM2AXI_WR_HAZARD_EN
    localparam int LSB = $clog2(STRB_W);
    logic fifo_full, fifo_empty, fifo_hit;
    wr_pending_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(ADDR_W), .LSB(LSB)) u_pending (
        .clk, .reset,
        .push(accept), .push_data(data_sram_addr), .pop(b_hs),
        .match_addr(hz_addr), .full(fifo_full), .empty(fifo_empty), .match(fifo_hit)
    );
    assign room   = (cnt < CW'(MAX_OUTSTANDING)) && !fifo_full;
    assign hz_hit = fifo_hit || (state == SEND && awaddr_q[ADDR_W-1:LSB] == hz_addr[ADDR_W-1:LSB]);
    assign unused = ^{axi.bid, axi.bresp ^ RESP_OKAY, fifo_empty};
`else
    assign room   = cnt < CW'(MAX_OUTSTANDING);
    assign unused = ^{axi.bid, axi.bresp ^ RESP_OKAY};
`endif
    assign accept    = reset && data_sram_req && data_sram_wr && state == IDLE && room;
    assign aw_hs     = awvalid_q && axi.awready;
    assign w_hs      = wvalid_q && axi.wready;
    assign b_hs      = axi.bvalid && axi.bready;
    assign send_done = (!awvalid_q || aw_hs) && (!wvalid_q || w_hs);
    assign data_sram_addr_ok = accept;
    assign data_sram_data_ok = b_hs;
    assign wr_busy   = cnt != '0 || state != IDLE;
    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = LEN_SINGLE;
    assign axi.awsize  = awsize_q;
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = awvalid_q;
    assign axi.wid     = AXI_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = cnt != '0;
    always_comb begin
        state_nxt = (state == IDLE) ? (accept ? SEND : IDLE) : (send_done ? IDLE : SEND);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt + CW'(accept) - CW'(b_hs);
            if (accept) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                awaddr_q  <= data_sram_addr;
                awsize_q  <= data_sram_size;
                wdata_q   <= data_sram_wdata;
                wstrb_q   <= data_sram_wstrb;
            end else begin
                if (aw_hs) awvalid_q <= 1'b0;
                if (w_hs) wvalid_q <= 1'b0;
            end
        end
    end
endmodule
